// File: rtl/ad_absorb_if.sv
// Handshake/data bundle between the AD-absorb block and its neighbours.
// Suffixes are from the ad_absorb point of view.
interface ad_absorb_if #(
    parameter int AD_LEN_W = 16
);
    logic                start_i;
    logic [292:0]        state_in_i;
    logic [AD_LEN_W-1:0] ad_len_i;
    logic [7:0]          ad_data_i;
    logic                ad_valid_i;
    logic                ad_ready_o;
    logic [292:0]        state_out_o;
    logic                busy_o;
    logic                done_o;

    modport master (
        output start_i, state_in_i, ad_len_i, ad_data_i, ad_valid_i,
        input  ad_ready_o, state_out_o, busy_o, done_o
    );

    modport slave (
        input  start_i, state_in_i, ad_len_i, ad_data_i, ad_valid_i,
        output ad_ready_o, state_out_o, busy_o, done_o
    );
endinterface

// File: rtl/ad_absorb.sv
// ACORN-128 associated-data phase: absorbs AD one bit per clock, then runs the
// 256-step AD padding on the 293-bit state.
module ad_absorb #(
    parameter int AD_LEN_W = 16,
    parameter int PAD_BITS = 256
) (
    input  logic        clk,
    input  logic        rst,
    ad_absorb_if.slave  bus
);
    localparam int                PAD_W    = $clog2(PAD_BITS);
    localparam logic [PAD_W-1:0]  PAD_LAST = PAD_W'(PAD_BITS - 1);
    localparam logic [PAD_W-1:0]  PAD_HALF = PAD_W'(PAD_BITS / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SHIFT,
        S_PAD,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [292:0]        st_q, st_d;
    logic [7:0]          byte_q, byte_d;
    logic [2:0]          bit_q, bit_d;
    logic [PAD_W-1:0]    pad_q, pad_d;
    logic [AD_LEN_W-1:0] left_q, left_d;
    logic                ready, busy, done;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // One state_update128 step; each LFSR tap update reads the not-yet-updated
    // lower tap, and ks/f read the updated taps.
    function automatic logic [292:0] acorn_step(input logic [292:0] s, input logic m,
                                                input logic ca, input logic cb);
        logic [292:0] t;
        logic         ks;
        logic         f;
        t      = s;
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];
        ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
        f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
        return {f ^ m, t[292:1]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            pad_q   <= '0;
            left_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational process.
            state_q <= state_d;
            st_q    <= st_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            pad_q   <= pad_d;
            left_q  <= left_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        st_d    = st_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        pad_d   = pad_q;
        left_d  = left_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    st_d    = bus.state_in_i;
                    left_d  = bus.ad_len_i;
                    pad_d   = '0;
                    state_d = (bus.ad_len_i == '0) ? S_PAD : S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (bus.ad_valid_i) begin
                    byte_d  = bus.ad_data_i;
                    bit_d   = '0;
                    if (left_q != '0) left_d = left_q - 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy  = 1'b1;
                st_d  = acorn_step(st_q, byte_q[bit_q], 1'b1, 1'b1);
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    if (left_q != '0) begin
                        state_d = S_WAIT_BYTE;
                    end else begin
                        pad_d   = '0;
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                busy  = 1'b1;
                st_d  = acorn_step(st_q, pad_q == '0, pad_q < PAD_HALF, 1'b1);
                pad_d = pad_q + 1'b1;
                if (pad_q == PAD_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ad_ready_o  = ready;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.state_out_o = st_q;
endmodule

// File: tb/tb_ad_absorb.sv
// Directed bench for ad_absorb: latencies, handshake counts and final state
// against an in-bench ACORN-128 reference model.
module tb_ad_absorb;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [7:0] ad_mem [16];

    ad_absorb_if #(.AD_LEN_W(4)) bus ();

    ad_absorb #(.AD_LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [292:0] got, input logic [292:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_maj(input bit x, input bit y, input bit z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Reference step written the way the ACORN C code does it: in-place tap
    // updates, then a bit-by-bit shift.
    function automatic logic [292:0] ref_step(input logic [292:0] st, input bit m,
                                              input bit ca, input bit cb);
        logic [292:0] s;
        bit ks;
        bit f;
        s = st;
        s[289] ^= s[235] ^ s[230];
        s[230] ^= s[196] ^ s[193];
        s[193] ^= s[160] ^ s[154];
        s[154] ^= s[111] ^ s[107];
        s[107] ^= s[66]  ^ s[61];
        s[61]  ^= s[23]  ^ s[0];
        ks = s[12] ^ s[154] ^ ref_maj(s[235], s[61], s[193])
           ^ (s[230] ? s[111] : s[66]);
        f  = s[0] ^ !s[107] ^ ref_maj(s[244], s[23], s[160])
           ^ (ca & s[196]) ^ (cb & ks);
        for (int j = 0; j < 292; j++) s[j] = s[j+1];
        s[292] = f ^ m;
        return s;
    endfunction

    function automatic logic [292:0] ref_init_zero();
        logic [292:0] s;
        s = '0;
        for (int i = 0; i < 1792; i++) s = ref_step(s, i == 256, 1'b1, 1'b1);
        return s;
    endfunction

    function automatic logic [292:0] ref_absorb(input logic [292:0] st, input int len);
        logic [292:0] s;
        s = st;
        for (int b = 0; b < len; b++)
            for (int i = 0; i < 8; i++) s = ref_step(s, ad_mem[b][i], 1'b1, 1'b1);
        for (int i = 0; i < 256; i++) s = ref_step(s, i == 0, i < 128, 1'b1);
        return s;
    endfunction

    // Starts one operation and runs it cycle by cycle, sampling at negedge.
    // c counts clock edges after the start edge.
    task automatic run_op(input logic [292:0] st, input int len, input int stall_idx,
                          input int stall_n, input bit noise, input int abort_at,
                          output int lat, output int rdy, output int hs,
                          output int busy_n, output int dones, output logic [292:0] res);
        int b;
        int stall_left;
        int c;
        bit seen;
        b = 0; stall_left = stall_n; c = 0; seen = 1'b0;
        lat = -1; rdy = 0; hs = 0; busy_n = 0; dones = 0; res = '0;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.state_in_i = st;
        bus.ad_len_i   = 4'(len);
        bus.ad_valid_i = 1'b0;
        @(posedge clk);
        while (c < 600) begin
            @(negedge clk);
            if (c == abort_at) begin
                bus.start_i    = 1'b0;
                bus.ad_valid_i = 1'b0;
                return;
            end
            if (bus.busy_o) busy_n++;
            if (bus.done_o) begin
                dones++;
                if (!seen) begin
                    lat  = c;
                    res  = bus.state_out_o;
                    seen = 1'b1;
                end
            end
            if (seen && c >= lat + 4) break;
            bus.start_i = noise && bus.busy_o;
            if (bus.ad_ready_o) rdy++;
            if (bus.ad_ready_o && b == stall_idx && stall_left > 0) begin
                bus.ad_valid_i = 1'b0;
                stall_left--;
            end else begin
                bus.ad_valid_i = (b < len);
                bus.ad_data_i  = ad_mem[b[3:0]];
            end
            if (bus.ad_ready_o && bus.ad_valid_i) begin
                hs++;
                b++;
            end
            c++;
        end
        bus.start_i    = 1'b0;
        bus.ad_valid_i = 1'b0;
    endtask

    initial begin
        logic [292:0] init_st;
        logic [292:0] exp_t1;
        logic [292:0] res;
        int lat, rdy, hs, busy_n, dones;

        checks = 0; failures = 0;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.state_in_i = '0; bus.ad_len_i = '0;
        bus.ad_data_i = '0; bus.ad_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) ad_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_state_out", bus.state_out_o, '0);
        check("rst_busy",      bus.busy_o,      1'b0);
        check("rst_done",      bus.done_o,      1'b0);
        check("rst_ad_ready",  bus.ad_ready_o,  1'b0);
        rst = 1'b0;

        // T1: empty AD on zero state
        exp_t1 = ref_absorb('0, 0);
        run_op('0, 0, -1, 0, 1'b0, -1, lat, rdy, hs, busy_n, dones, res);
        check("t1_latency", lat,    256);
        check("t1_busy",    busy_n, 256);
        check("t1_ready",   rdy,    0);
        check("t1_dones",   dones,  1);
        check("t1_state",   res,    exp_t1);
        check("t1_hold",    bus.state_out_o, exp_t1);

        // T2: one byte A5 on the key=0/iv=0 post-init state
        init_st   = ref_init_zero();
        ad_mem[0] = 8'hA5;
        run_op(init_st, 1, -1, 0, 1'b0, -1, lat, rdy, hs, busy_n, dones, res);
        check("t2_latency", lat,   265);
        check("t2_ready",   rdy,   1);
        check("t2_hs",      hs,    1);
        check("t2_dones",   dones, 1);
        check("t2_state",   res,   ref_absorb(init_st, 1));

        // T3: three bytes, 5-cycle stall before the second byte
        ad_mem[0] = 8'h01; ad_mem[1] = 8'h02; ad_mem[2] = 8'h03;
        run_op(init_st, 3, 1, 5, 1'b0, -1, lat, rdy, hs, busy_n, dones, res);
        check("t3_latency", lat,   288);
        check("t3_hs",      hs,    3);
        check("t3_ready",   rdy,   8);
        check("t3_state",   res,   ref_absorb(init_st, 3));

        // T4: start held high whenever busy (WAIT, SHIFT and PAD)
        ad_mem[0] = 8'h3C; ad_mem[1] = 8'hC3;
        run_op(init_st, 2, -1, 0, 1'b1, -1, lat, rdy, hs, busy_n, dones, res);
        check("t4_latency", lat,   274);
        check("t4_hs",      hs,    2);
        check("t4_dones",   dones, 1);
        check("t4_state",   res,   ref_absorb(init_st, 2));

        // T5: asynchronous reset at pad_cnt=100, then a clean rerun of T1
        run_op('0, 0, -1, 0, 1'b0, 100, lat, rdy, hs, busy_n, dones, res);
        rst = 1'b1;
        #1;
        check("t5_rst_state_out", bus.state_out_o, '0);
        check("t5_rst_busy",      bus.busy_o,      1'b0);
        check("t5_rst_done",      bus.done_o,      1'b0);
        check("t5_rst_ready",     bus.ad_ready_o,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op('0, 0, -1, 0, 1'b0, -1, lat, rdy, hs, busy_n, dones, res);
        check("t5_latency", lat,   256);
        check("t5_dones",   dones, 1);
        check("t5_state",   res,   exp_t1);

        // T6: maximum length for a 4-bit ad_len
        for (int i = 0; i < 16; i++) ad_mem[i] = 8'(i * 37 + 11);
        run_op(init_st, 15, -1, 0, 1'b0, -1, lat, rdy, hs, busy_n, dones, res);
        check("t6_latency", lat,   391);
        check("t6_hs",      hs,    15);
        check("t6_ready",   rdy,   15);
        check("t6_dones",   dones, 1);
        check("t6_state",   res,   ref_absorb(init_st, 15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
